state_timer: RTL

//  Consumer end of the per-state time-limit table: watches present_state, takes the

---
 rtl/state_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/state_timer.sv
// Per-state countdown: reloads the time limit on every controller state change, ticks it down each ms,
// and pulses expired when it runs out. Define STATE_TIMER_PAUSE_EN to add a pause input that freezes RUN.
module state_timer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int STATE_W     = 4,
  parameter int T_W         = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] present_state,
  input  logic [T_W-1:0]     t,
  output logic [T_W-1:0]     remaining,
  output logic               busy,
  output logic               expired
`ifdef STATE_TIMER_PAUSE_EN
  ,
  input  logic               pause
`endif
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [STATE_W-1:0] prev_state_reg;
  logic [PW-1:0]      prescaler_reg, prescaler_next;
  logic [T_W-1:0]     remaining_reg, remaining_next;
  logic               busy_reg, busy_next;
  logic               expired_reg, expired_next;
  logic               change;
  logic               hold;

`ifdef STATE_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign change = (present_state != prev_state_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_state_reg <= '0;
      prescaler_reg  <= '0;
      remaining_reg  <= '0;
      busy_reg       <= 1'b0;
      expired_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_state_reg <= present_state;
      prescaler_reg  <= prescaler_next;
      remaining_reg  <= remaining_next;
      busy_reg       <= busy_next;
      expired_reg    <= expired_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    remaining_next = remaining_reg;
    busy_next      = busy_reg;
    expired_next   = 1'b0;
    // A state change overrides everything, including a final tick on the same edge.
    if (change) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD: begin
          if (t == '0) begin
            state_next     = IDLE;
            remaining_next = '0;
            busy_next      = 1'b0;
          end else begin
            state_next     = RUN;
            remaining_next = t;
            prescaler_next = '0;
            busy_next      = 1'b1;
          end
        end
        RUN: begin
          if (!hold) begin
            if (prescaler_reg == PRE_MAX) begin
              prescaler_next = '0;
              if (remaining_reg <= T_W'(1)) begin
                remaining_next = '0;
                expired_next   = 1'b1;
                busy_next      = 1'b0;
                state_next     = DONE;
              end else begin
                remaining_next = remaining_reg - T_W'(1);
              end
            end else begin
              prescaler_next = prescaler_reg + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign remaining = remaining_reg;
  assign busy      = busy_reg;
  assign expired   = expired_reg;

endmodule
